conv_pool_layer_ctrl: RTL

- Parametrised convolution + max-pool layer sequencer for the CNN datapath.
- Walks every output channel and every pooled output position, and gathers each KxK input window from the feature buffer.
- Issues window/kernel/bias to the shared MAC calc unit over a valid/ready handshake, max-pools the returned conv results, and optionally applies ReLU.
- Writes the pooled word back to the output buffer; sits between the feature-map buffers and the calc unit, one instance per conv/pool layer.

---
 rtl/conv_pool_layer_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_pool_layer_ctrl.sv
// rtl/conv_pool_layer_ctrl.sv - conv + 2x2 max-pool layer sequencer feeding the shared MAC calc unit
module conv_pool_layer_ctrl #(
  parameter int WIDTH   = 16,
  parameter int K       = 5,
  parameter int IN_W    = 32,
  parameter int IN_H    = 32,
  parameter int N_KER   = 6,
  parameter int POOL_EN = 1,
  parameter int RELU_EN = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           layer_en_i,
  output logic                           busy_o,
  output logic                           output_buf_en_o,
  output logic [7:0]                     ker_idx_o,
  input  logic [K*K*WIDTH-1:0]           ker_data_i,
  input  logic [WIDTH-1:0]               bias_i,
  output logic                           buf_rd_en_o,
  output logic [31:0]                    buf_rd_addr_o,
  input  logic [K*WIDTH-1:0]             data_from_buf_i,
  output logic [(2*K*K+1)*WIDTH-1:0]     data_to_calc_o,
  output logic                           calc_valid_o,
  input  logic                           calc_ready_i,
  input  logic                           calc_res_valid_i,
  input  logic [WIDTH-1:0]               data_from_calc_i,
  output logic                           buf_wr_en_o,
  output logic [31:0]                    buf_wr_addr_o,
  output logic [WIDTH-1:0]               data_to_buf_o
);
  localparam int OW   = IN_W - K + 1;
  localparam int OH   = IN_H - K + 1;
  localparam int PW   = (POOL_EN != 0) ? OW / 2 : OW;
  localparam int PH   = (POOL_EN != 0) ? OH / 2 : OH;
  localparam int GRP  = (POOL_EN != 0) ? 4 : 1;
  localparam int KK   = K * K;
  localparam int WINW = KK * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_KER, S_FETCH, S_ISSUE, S_WAIT_RES, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       kc_q, kc_d, pr_q, pr_d, pc_q, pc_d;
  logic [1:0]        sp_q, sp_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WINW-1:0]   win_q, win_d, ker_q, ker_d;
  logic [WIDTH-1:0]  bias_q, bias_d, max_q, max_d;
  logic              busy_q, busy_d, obe_q, obe_d, rd_en_q, rd_en_d;
  logic              valid_q, valid_d, wr_en_q, wr_en_d;
  logic [31:0]       rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [7:0]        ker_idx_q, ker_idx_d;
  logic [15:0]       oy, ox;

  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    pr_d    = pr_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    ker_d   = ker_q;
    bias_d  = bias_q;
    max_d   = max_q;

    case (state_q)
      S_IDLE: begin
        if (layer_en_i) begin
          state_d = S_LOAD_KER;
          kc_d    = '0;
          pr_d    = '0;
          pc_d    = '0;
          sp_d    = '0;
          cnt_d   = '0;
        end
      end
      S_LOAD_KER: begin
        // ROM answers one cycle after the address settles, so sample on the second cycle
        if (cnt_q == 8'd1) begin
          ker_d   = ker_data_i;
          bias_d  = bias_i;
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FETCH: begin
        for (int i = 0; i < K; i++) begin
          if (cnt_q == 8'(i + 1)) begin
            for (int j = 0; j < K; j++) begin
              win_d[(KK - 1 - (i * K + j)) * WIDTH +: WIDTH] = data_from_buf_i[j * WIDTH +: WIDTH];
            end
          end
        end
        if (cnt_q == 8'(K)) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ISSUE: begin
        if (calc_ready_i) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (calc_res_valid_i) begin
          if (sp_q == 2'd0 || $signed(data_from_calc_i) > $signed(max_q)) max_d = data_from_calc_i;
          if (sp_q == 2'(GRP - 1)) begin
            state_d = S_WRITE;
          end else begin
            sp_d    = sp_q + 2'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_WRITE: begin
        sp_d    = '0;
        state_d = S_FETCH;
        if (pc_q == 16'(PW - 1)) begin
          pc_d = '0;
          if (pr_q == 16'(PH - 1)) begin
            pr_d = '0;
            if (kc_q == 16'(N_KER - 1)) begin
              state_d = S_DONE;
            end else begin
              kc_d    = kc_q + 16'd1;
              state_d = S_LOAD_KER;
            end
          end else begin
            pr_d = pr_q + 16'd1;
          end
        end else begin
          pc_d = pc_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the upcoming state so each strobe lines up with its state
    oy        = (POOL_EN != 0) ? ((pr_d << 1) + 16'(sp_d[1])) : pr_d;
    ox        = (POOL_EN != 0) ? ((pc_d << 1) + 16'(sp_d[0])) : pc_d;
    busy_d    = (state_d != S_IDLE);
    obe_d     = (state_d == S_DONE);
    valid_d   = (state_d == S_ISSUE);
    rd_en_d   = (state_d == S_FETCH) && (cnt_d < 8'(K));
    rd_addr_d = rd_en_d ? ((32'(oy) + 32'(cnt_d)) * 32'(IN_W) + 32'(ox)) : rd_addr_q;
    wr_en_d   = (state_d == S_WRITE);
    wr_addr_d = wr_en_d ? (32'(kc_d) * 32'(PW * PH) + 32'(pr_d) * 32'(PW) + 32'(pc_d)) : wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) wr_data_d = (RELU_EN != 0 && max_d[WIDTH-1]) ? '0 : max_d;
    ker_idx_d = (state_d == S_LOAD_KER) ? kc_d[7:0] : ker_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      kc_q      <= '0;
      pr_q      <= '0;
      pc_q      <= '0;
      sp_q      <= '0;
      cnt_q     <= '0;
      win_q     <= '0;
      ker_q     <= '0;
      bias_q    <= '0;
      max_q     <= '0;
      busy_q    <= 1'b0;
      obe_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ker_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      kc_q      <= kc_d;
      pr_q      <= pr_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      ker_q     <= ker_d;
      bias_q    <= bias_d;
      max_q     <= max_d;
      busy_q    <= busy_d;
      obe_q     <= obe_d;
      rd_en_q   <= rd_en_d;
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ker_idx_q <= ker_idx_d;
    end
  end

  assign busy_o          = busy_q;
  assign output_buf_en_o = obe_q;
  assign ker_idx_o       = ker_idx_q;
  assign buf_rd_en_o     = rd_en_q;
  assign buf_rd_addr_o   = rd_addr_q;
  assign data_to_calc_o  = {win_q, ker_q, bias_q};
  assign calc_valid_o    = valid_q;
  assign buf_wr_en_o     = wr_en_q;
  assign buf_wr_addr_o   = wr_addr_q;
  assign data_to_buf_o   = wr_data_q;
endmodule
